// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: parity modes, transmitter state
// encoding and baud divider helpers.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  function automatic int calc_cnt_w(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_param_fifo.sv
// Synchronous FIFO with registered full/empty flags; shared with the planned receiver.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nx;
  logic             do_wr, do_rd;

  // full is judged before any same-cycle pop, so a write into a full FIFO is dropped
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && (count != '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_nx = count;
    if (do_wr && !do_rd)
      count_nx = count + (AW+1)'(1);
    else if (!do_wr && do_rd)
      count_nx = count - (AW+1)'(1);
  end

  // empty trails the count by one cycle, giving a two-edge write-to-start latency
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count_nx;
      full  <= (count_nx == (AW+1)'(DEPTH));
      empty <= (count == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter with input FIFO and back-to-back framing.
// Optional macro UART_TX_OVERFLOW_EN adds a sticky overflow output.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 empty,
  output logic                 busy,
  output logic                 TxD
`ifdef UART_TX_OVERFLOW_EN
  ,
  output logic                 overflow
`endif
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int CNT_W = calc_cnt_w(DIV);

  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_chk
    $error("uart_tx_param: illegal parameter combination");
  end

  tx_state_e            state, state_nx;
  logic [CNT_W-1:0]     baud_cnt, cnt_nx;
  logic [3:0]           bit_cnt, bit_nx;
  logic                 txd_nx, pop, shift, bit_end;
  logic [DATA_BITS-1:0] shreg, fifo_rd_data;
  logic                 par_bit;

  sync_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .rd_en  (pop),
    .rd_data(fifo_rd_data),
    .full   (full),
    .empty  (empty)
  );

  assign busy    = (state != ST_IDLE);
  assign bit_end = (baud_cnt == CNT_W'(DIV - 1));

  always_comb begin
    state_nx = state;
    cnt_nx   = baud_cnt + CNT_W'(1);
    bit_nx   = bit_cnt;
    txd_nx   = TxD;
    pop      = 1'b0;
    shift    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        txd_nx = 1'b1;
        if (!empty) begin
          pop      = 1'b1;
          state_nx = ST_START;
          txd_nx   = 1'b0;
        end
      end
      ST_START: begin
        if (bit_end) begin
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = ST_DATA;
          txd_nx   = shreg[0];
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (bit_cnt == 4'(DATA_BITS - 1)) begin
            bit_nx = '0;
            if (PARITY != PAR_NONE) begin
              state_nx = ST_PARITY;
              txd_nx   = par_bit;
            end else begin
              state_nx = ST_STOP;
              txd_nx   = 1'b1;
            end
          end else begin
            bit_nx = bit_cnt + 4'd1;
            shift  = 1'b1;
            txd_nx = shreg[1];
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          cnt_nx   = '0;
          bit_nx   = '0;
          state_nx = ST_STOP;
          txd_nx   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          cnt_nx = '0;
          if (bit_cnt == 4'(STOP_BITS - 1)) begin
            bit_nx = '0;
            // a queued character starts immediately, no idle gap between frames
            if (!empty) begin
              pop      = 1'b1;
              state_nx = ST_START;
              txd_nx   = 1'b0;
            end else begin
              state_nx = ST_IDLE;
              txd_nx   = 1'b1;
            end
          end else begin
            bit_nx = bit_cnt + 4'd1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        txd_nx   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      TxD      <= 1'b1;
    end else begin
      state    <= state_nx;
      baud_cnt <= cnt_nx;
      bit_cnt  <= bit_nx;
      TxD      <= txd_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (pop) begin
      shreg   <= fifo_rd_data;
      par_bit <= (^fifo_rd_data) ^ (PARITY == PAR_ODD);
    end else if (shift) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef UART_TX_OVERFLOW_EN
  always_ff @(posedge clk) begin
    if (reset)
      overflow <= 1'b0;
    else if (wr_en && full)
      overflow <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// Scoreboard bench for uart_tx_param: four configurations (8N1, 8E1, 8O1, 7N2) at DIV = 16.
module tb_uart_tx_param;

  localparam int DIV   = 16;
  localparam int DEPTH = 4;

  logic       clk;
  logic       reset;
  logic [8:0] wdat;
  logic [3:0] wen, full_v, empty_v, busy_v, txd_v;
`ifdef UART_TX_OVERFLOW_EN
  logic [3:0] ov_v;
`endif

  int         total = 0;
  int         bad   = 0;
  int         cur   = 0;
  bit         mon_en = 0;
  logic [8:0] exp_q[$];

  uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8n1 (
    .clk(clk), .reset(reset), .wr_data(wdat[7:0]), .wr_en(wen[0]), .full(full_v[0]),
    .empty(empty_v[0]), .busy(busy_v[0]), .TxD(txd_v[0])
`ifdef UART_TX_OVERFLOW_EN
    , .overflow(ov_v[0])
`endif
  );
  uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8e1 (
    .clk(clk), .reset(reset), .wr_data(wdat[7:0]), .wr_en(wen[1]), .full(full_v[1]),
    .empty(empty_v[1]), .busy(busy_v[1]), .TxD(txd_v[1])
`ifdef UART_TX_OVERFLOW_EN
    , .overflow(ov_v[1])
`endif
  );
  uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)) u_8o1 (
    .clk(clk), .reset(reset), .wr_data(wdat[7:0]), .wr_en(wen[2]), .full(full_v[2]),
    .empty(empty_v[2]), .busy(busy_v[2]), .TxD(txd_v[2])
`ifdef UART_TX_OVERFLOW_EN
    , .overflow(ov_v[2])
`endif
  );
  uart_tx_param #(.CLK_FREQ(16), .BAUD(1), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)) u_7n2 (
    .clk(clk), .reset(reset), .wr_data(wdat[6:0]), .wr_en(wen[3]), .full(full_v[3]),
    .empty(empty_v[3]), .busy(busy_v[3]), .TxD(txd_v[3])
`ifdef UART_TX_OVERFLOW_EN
    , .overflow(ov_v[3])
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_dbits(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int cfg_stop(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int nbits(input int i);
    return 1 + cfg_dbits(i) + ((cfg_par(i) != 0) ? 1 : 0) + cfg_stop(i);
  endfunction

  // Expected line levels, one per bit period: start, data LSB first, parity, stop(s)
  function automatic logic [12:0] model_frame(input int i, input logic [8:0] c);
    logic [12:0] f;
    int n, ones;
    f    = '1;
    f[0] = 1'b0;
    n    = cfg_dbits(i);
    ones = 0;
    for (int b = 0; b < n; b++) begin
      f[1+b] = c[b];
      ones  += int'(c[b]);
    end
    if (cfg_par(i) == 2) f[1+n] = ((ones % 2) != 0);
    else if (cfg_par(i) == 1) f[1+n] = ((ones % 2) == 0);
    return f;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: called on the first cycle of a start bit, samples every cycle of the frame
  task automatic check_frame();
    int          i, nb;
    logic [12:0] obs;
    logic        v;
    bit          steady;
    logic [8:0]  c;
    i      = cur;
    nb     = nbits(i);
    obs    = '1;
    steady = 1'b1;
    v      = 1'b1;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < DIV; k++) begin
        if (!(b == 0 && k == 0)) @(negedge clk);
        if (!mon_en) return;
        if (k == 0) v = txd_v[i];
        else if (txd_v[i] !== v) steady = 1'b0;
      end
      obs[b] = v;
    end
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL unexpected_frame: got frame %0h expected none", obs);
    end else begin
      c = exp_q.pop_front();
      chk("frame_bits", int'(obs), int'(model_frame(i, c)));
    end
    chk("bit_timing", int'(steady), 1);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && txd_v[cur] === 1'b0) check_frame();
    end
  end

  // Writes n characters on consecutive cycles from idle, then drains; the first
  // DEPTH+1 are accepted (one is popped while the FIFO fills), the rest dropped.
  task automatic run(input int idx, input int n, input logic [8:0] base, input bit rnd);
    int nb, first, last, acc, tfall, t;
    nb = 0; first = -1; last = -1; acc = 0; tfall = -1;
    cur = idx;
    for (t = 0; t < 4000; t++) begin
      @(negedge clk);
      if (busy_v[idx]) begin
        nb++;
        if (first < 0) first = t;
        last = t;
      end
      if (txd_v[idx] === 1'b0 && tfall < 0) tfall = t;
      if (n == 6 && t == 6) chk("full_flag", int'(full_v[idx]), 1);
      if (t < n) begin
        wen[idx] = 1'b1;
        wdat     = rnd ? 9'($urandom) : base + 9'(t);
        if (t <= DEPTH) begin
          exp_q.push_back(wdat);
          acc++;
        end
      end else begin
        wen = '0;
        if (t > n && exp_q.size() == 0 && !busy_v[idx]) break;
      end
    end
    chk("start_latency", tfall, 3);
    chk("queue_left", exp_q.size(), 0);
    chk("busy_cycles", nb, acc * nbits(idx) * DIV);
    chk("busy_gap", last - first + 1, nb);
    chk("empty_end", int'(empty_v[idx]), 1);
  endtask

  initial begin
    logic [8:0] c0;
    int lows;
    reset = 1'b1;
    wen   = '0;
    wdat  = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk("rst_txd", int'(txd_v[i]), 1);
      chk("rst_busy", int'(busy_v[i]), 0);
      chk("rst_empty", int'(empty_v[i]), 1);
      chk("rst_full", int'(full_v[i]), 0);
    end
`ifdef UART_TX_OVERFLOW_EN
    chk("rst_overflow", int'(ov_v[0]), 0);
`endif
    reset  = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);

    run(0, 1, 9'h0A5, 1'b0);
    run(1, 1, 9'h0A5, 1'b0);
    run(2, 1, 9'h0A5, 1'b0);
    run(0, 3, 9'h001, 1'b0);
`ifdef UART_TX_OVERFLOW_EN
    chk("overflow_before", int'(ov_v[0]), 0);
`endif
    run(0, 6, 9'h010, 1'b0);
`ifdef UART_TX_OVERFLOW_EN
    chk("overflow_set", int'(ov_v[0]), 1);
`endif
    run(3, 1, 9'h07F, 1'b0);
    for (int r = 0; r < 6; r++)
      run(int'($urandom_range(0, 3)), int'($urandom_range(1, 6)), 9'h000, 1'b1);

    // Reset during data bit 3 with two characters still queued
    mon_en = 1'b0;
    cur    = 0;
    c0     = 9'($urandom);
    for (int t = 0; t < 3; t++) begin
      @(negedge clk);
      wen[0] = 1'b1;
      wdat   = (t == 0) ? c0 : 9'($urandom);
    end
    @(negedge clk);
    wen = '0;
    repeat (66) @(negedge clk);
    chk("pre_reset_busy", int'(busy_v[0]), 1);
    chk("pre_reset_bit3", int'(txd_v[0]), int'(c0[3]));
    reset = 1'b1;
    @(negedge clk);
    chk("mid_reset_txd", int'(txd_v[0]), 1);
    chk("mid_reset_busy", int'(busy_v[0]), 0);
    chk("mid_reset_empty", int'(empty_v[0]), 1);
`ifdef UART_TX_OVERFLOW_EN
    chk("mid_reset_overflow", int'(ov_v[0]), 0);
`endif
    reset = 1'b0;
    lows  = 0;
    repeat (300) begin
      @(negedge clk);
      if (txd_v[0] !== 1'b1 || busy_v[0] !== 1'b0) lows++;
    end
    chk("no_resume", lows, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
